imem_rom_responder: RTL and testbench
=====================================

# imem_rom_responder

Synthesizable instruction-memory responder for the cpu_top instruction fetch port. It accepts fetch requests on the imem_req channel and returns 32-bit instruction words on the imem_resp channel after a fixed, parameterised latency. It supports up to QDEPTH outstanding requests and honours response backpressure. A load port fills the array before or during a run. It replaces the behavioural ROM model in system-level benches and FPGA builds.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two; AW = clog2(DEPTH_WORDS).
- LATENCY, 1: accept-to-response cycles, legal 1..4.
- QDEPTH, 2: maximum outstanding requests (pipeline plus response FIFO), legal 1..4.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- imem_req_valid  in  1  fetch request valid.
- imem_req_addr  in  32  byte address of the fetch.
- imem_req_ready  out  1  responder can accept a request this cycle.
- imem_resp_valid  out  1  response word valid.
- imem_resp_data  out  32  instruction word.
- imem_resp_err  out  1  response is for a misaligned or out-of-range address.
- imem_resp_ready  in  1  CPU consumes the response.
- ld_we  in  1  load-port write enable.
- ld_addr  in  AW  load-port word index.
- ld_data  in  32  load-port write data.

## Operation
- Accept: a request is accepted on a rising edge when imem_req_valid && imem_req_ready. The memory is read at that edge. If ld_we targets the same word on the same edge, the read returns the old contents.
- Index: the word index is imem_req_addr[AW+1:2]. A request is in range when imem_req_addr[1:0]==0 and imem_req_addr < DEPTH_WORDS*4.
- Out-of-range or misaligned request: data = 32'h00000013 (NOP), err = 1. The request still completes normally and still occupies a slot.
- Pipeline: each accepted request carries {data, err} through a LATENCY-stage shift pipeline, then enters an in-order response FIFO of QDEPTH entries. Responses are never reordered or dropped.
- Outstanding count: cnt (0..QDEPTH) counts entries in the pipeline plus the FIFO.
  - cnt increments on accept.
  - cnt decrements on pop (imem_resp_valid && imem_resp_ready).
  - Accept and pop on the same edge leave cnt unchanged.
- imem_req_ready = (cnt < QDEPTH). It depends on registered state only, with no combinational path from imem_req_valid or imem_resp_ready.
- FIFO overflow is structurally impossible because of the cnt limit. Implementations assert this in simulation.
- imem_resp_valid = FIFO non-empty. imem_resp_data and imem_resp_err come from the FIFO head.
- Response hold rule: while imem_resp_valid && !imem_resp_ready, resp_data and resp_err hold stable.
- Load port: ld_we writes ld_data to mem[ld_addr] on the edge. The load port is independent of reset_n and of the fetch traffic.
- The memory array is not reset. Simulation initialises every word to 32'h00000013.

## Timing
- Reset (reset_n low at an edge) clears the pipeline valid bits, the FIFO pointers and cnt.
  - Outputs after reset: imem_req_ready = 1 (because QDEPTH ≥ 1), imem_resp_valid = 0, imem_resp_data = 0, imem_resp_err = 0.
  - Memory contents are preserved.
- Reset mid-operation: all in-flight requests are discarded and no response is produced for them. The first request after reset_n rises may be accepted on the first edge with reset_n high.
- Latency: a request accepted at edge N, with the FIFO empty, gives imem_resp_valid = 1 after edge N+LATENCY. The earliest pop is at edge N+LATENCY+1.
- Throughput: with imem_resp_ready held high and QDEPTH ≥ LATENCY+1, one response per cycle is sustained. Otherwise throughput is QDEPTH responses per LATENCY+1 cycles.
- Backpressure: when the FIFO is full and cnt == QDEPTH, imem_req_ready is 0 until the edge after the first pop.
- Pipeline stages advance every cycle and never stall. FIFO space is guaranteed by cnt.

## Test plan
- Basic fetch, LATENCY=1: load mem[0..2] = 0x00500093, 0x00700113, 0x002081B3. Issue addr 0, 4, 8 with resp_ready=1 → responses in order with those values, err=0, each valid exactly 1 cycle after its accept.
- Backpressure, QDEPTH=2: hold resp_ready=0 and issue 3 requests → exactly 2 accepted and req_ready=0. Data for addr 0 stays stable for 5 cycles. Raise resp_ready → all 3 responses arrive in order.
- Error paths: addr 0x00000402 (misaligned) and 0x00000400 (out of range for 256 words) → data 0x00000013, err=1 for both. The next request, addr 0, returns 0x00500093 with err=0.
- Latency sweep, LATENCY=3 and QDEPTH=4 with continuous requests and ready=1 → first valid 3 cycles after the first accept, then one response per cycle; 16 sequential words returned correctly.
- Same-edge load/read: accept addr 8 on the same edge as ld_we writing mem[2] = 0xDEADBEEF → response 0x002081B3. The next fetch of addr 8 returns 0xDEADBEEF.
- Reset mid-flight: 2 requests outstanding, assert reset_n=0 for 1 edge → resp_valid=0, req_ready=1, no stale response ever appears, and mem[0] is still 0x00500093 on a subsequent fetch.

Source files
------------

// File: rtl/imem_rom_responder_if.sv
// ----------------------------------------------------------------------------
// imem_rom_responder_if
//   Instruction-fetch channel between the CPU fetch unit and the instruction
//   memory responder.
//
//   imem_req_valid   master->slave  fetch request valid
//   imem_req_addr    master->slave  32-bit byte address of the fetch
//   imem_req_ready   slave->master  responder can accept a request this cycle
//   imem_resp_valid  slave->master  response word valid
//   imem_resp_data   slave->master  32-bit instruction word
//   imem_resp_err    slave->master  response is for a bad (misaligned/out-of-range) address
//   imem_resp_ready  master->slave  CPU consumes the response
// ----------------------------------------------------------------------------
interface imem_rom_responder_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        imem_resp_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output imem_resp_ready,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  imem_resp_ready,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_err
    );
endinterface

// File: rtl/imem_rom_responder.sv
// ----------------------------------------------------------------------------
// imem_rom_responder
//   Instruction-memory responder for the cpu_top fetch port. Each accepted
//   fetch reads a 32-bit word, travels through a LATENCY-stage pipeline and
//   lands in an in-order response FIFO. At most QDEPTH requests are
//   outstanding (pipeline plus FIFO), which is what keeps the FIFO from
//   overflowing. A load port fills the array at any time.
//
//   Parameters
//     DEPTH_WORDS  number of 32-bit words (power of two)
//     LATENCY      accept-to-response cycles, 1..4
//     QDEPTH       maximum outstanding requests, 1..4
//
//   Ports
//     clk       clock
//     reset_n   synchronous active-low reset (control state only)
//     imem      fetch channel, slave side
//     ld_we     load-port write enable
//     ld_addr   load-port word index
//     ld_data   load-port write data
// ----------------------------------------------------------------------------
module imem_rom_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1,
    parameter int QDEPTH      = 2,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                reset_n,
    imem_rom_responder_if.slave imem,
    input  logic                ld_we,
    input  logic [AW-1:0]       ld_addr,
    input  logic [31:0]         ld_data
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int          PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW       = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

    // Word-aligned and inside the array.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH_WORDS));
    endfunction

    // FIFO pointer advance; QDEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]        mem [DEPTH_WORDS];
    logic [AW-1:0]      rd_idx;
    logic               req_ok;
    logic               accept;
    logic               push;
    logic               pop;
    logic               req_ready;
    logic               resp_valid;

    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] err_p;
    logic [31:0]        data_p [LATENCY];

    logic [31:0]        fifo_data [QDEPTH];
    logic               fifo_err  [QDEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fcnt;
    logic [CW-1:0]      cnt;

    assign rd_idx     = imem.imem_req_addr[AW+1:2];
    assign req_ok     = addr_ok(imem.imem_req_addr);
    assign req_ready  = (cnt < QDEPTH_C);
    assign resp_valid = (fcnt != '0);
    assign accept     = imem.imem_req_valid && req_ready;
    assign push       = vld_p[LATENCY-1];
    assign pop        = resp_valid && imem.imem_resp_ready;

    assign imem.imem_req_ready  = req_ready;
    assign imem.imem_resp_valid = resp_valid;
    // Gate the head so an idle port shows zeros without resetting storage.
    assign imem.imem_resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
    assign imem.imem_resp_err   = resp_valid ? fifo_err[rd_ptr]  : 1'b0;

    // Load port: independent of reset and of fetch traffic. A fetch on the
    // same edge reads the old word because both sides use non-blocking updates.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Stage p0: memory read at the accept edge, then LATENCY-1 shift stages.
    always_ff @(posedge clk) begin
        data_p[0] <= req_ok ? mem[rd_idx] : NOP_WORD;
        err_p[0]  <= !req_ok;
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
            err_p[i]  <= err_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Pipeline exit -> response FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= data_p[LATENCY-1];
            fifo_err[wr_ptr]  <= err_p[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A full FIFO implies cnt == QDEPTH and an empty pipeline, so no push.
    a_no_fifo_overflow : assert property (
        @(posedge clk) disable iff (!reset_n) !(push && (fcnt == QDEPTH_C))
    );

endmodule

// File: tb/tb_imem_rom_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_rom_responder
//   Directed bench for imem_rom_responder. dut_a uses LATENCY=1, QDEPTH=2;
//   dut_b uses LATENCY=3, QDEPTH=4. Both share clock and reset.
// ----------------------------------------------------------------------------
module tb_imem_rom_responder;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] W0   = 32'h0050_0093;
    localparam logic [31:0] W1   = 32'h0070_0113;
    localparam logic [31:0] W2   = 32'h0020_81B3;
    localparam logic [31:0] WNEW = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        a_ld_we;
    logic [7:0]  a_ld_addr;
    logic [31:0] a_ld_data;
    logic        b_ld_we;
    logic [7:0]  b_ld_addr;
    logic [31:0] b_ld_data;

    imem_rom_responder_if a_if ();
    imem_rom_responder_if b_if ();

    imem_rom_responder #(.DEPTH_WORDS(256), .LATENCY(1), .QDEPTH(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .imem    (a_if),
        .ld_we   (a_ld_we),
        .ld_addr (a_ld_addr),
        .ld_data (a_ld_data)
    );

    imem_rom_responder #(.DEPTH_WORDS(256), .LATENCY(3), .QDEPTH(4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .imem    (b_if),
        .ld_we   (b_ld_we),
        .ld_addr (b_ld_addr),
        .ld_data (b_ld_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contents preloaded into dut_b for the sequential sweep.
    function automatic logic [31:0] b_word(input int k);
        return 32'hA500_0000 + 32'(k) * 32'h0001_0101;
    endfunction

    // Single fetch on dut_a with resp_ready high: checks the response shows
    // up exactly one cycle after the accept and is popped on the next edge.
    task automatic fetch_a(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic exp_e);
        int n;
        a_if.imem_req_valid  = 1'b1;
        a_if.imem_req_addr   = addr;
        a_if.imem_resp_ready = 1'b1;
        n = 0;
        while (!a_if.imem_req_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, a_if.imem_req_ready, 1);
        tick();
        a_if.imem_req_valid = 1'b0;
        a_ld_we = 1'b0;
        check({tag, "_early"}, a_if.imem_resp_valid, 0);
        tick();
        check({tag, "_valid"}, a_if.imem_resp_valid, 1);
        check({tag, "_data"}, a_if.imem_resp_data, exp_d);
        check({tag, "_err"}, a_if.imem_resp_err, exp_e);
        tick();
        check({tag, "_popped"}, a_if.imem_resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_d [16];
        logic        got_e [16];
        int          got_c [16];
        int          nresp;
        int          cyc;
        int          issued;
        int          first_acc;
        logic        acc;

        reset_n = 1'b0;
        a_ld_we = 1'b0; a_ld_addr = '0; a_ld_data = '0;
        b_ld_we = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        a_if.imem_req_valid = 1'b0; a_if.imem_req_addr = '0; a_if.imem_resp_ready = 1'b0;
        b_if.imem_req_valid = 1'b0; b_if.imem_req_addr = '0; b_if.imem_resp_ready = 1'b0;

        // Load both arrays while reset is held; the load port ignores reset.
        tick();
        for (int k = 0; k < 3; k++) begin
            a_ld_we   = 1'b1;
            a_ld_addr = 8'(k);
            a_ld_data = (k == 0) ? W0 : (k == 1) ? W1 : W2;
            tick();
        end
        a_ld_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            b_ld_we   = 1'b1;
            b_ld_addr = 8'(k);
            b_ld_data = b_word(k);
            tick();
        end
        b_ld_we = 1'b0;

        check("rst_a_req_ready", a_if.imem_req_ready, 1);
        check("rst_a_resp_valid", a_if.imem_resp_valid, 0);
        check("rst_a_resp_data", a_if.imem_resp_data, 0);
        check("rst_a_resp_err", a_if.imem_resp_err, 0);
        check("rst_b_req_ready", b_if.imem_req_ready, 1);
        check("rst_b_resp_valid", b_if.imem_resp_valid, 0);
        reset_n = 1'b1;

        // Basic fetches.
        fetch_a("f0", 32'h0, W0, 1'b0);
        fetch_a("f4", 32'h4, W1, 1'b0);
        fetch_a("f8", 32'h8, W2, 1'b0);

        // Backpressure: two accepts fill QDEPTH=2, third request waits.
        a_if.imem_resp_ready = 1'b0;
        a_if.imem_req_valid  = 1'b1;
        a_if.imem_req_addr   = 32'h0;
        tick();
        a_if.imem_req_addr   = 32'h4;
        tick();
        a_if.imem_req_addr   = 32'h8;
        check("bp_full_ready", a_if.imem_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", a_if.imem_resp_valid, 1);
            check("bp_hold_data", a_if.imem_resp_data, W0);
            check("bp_hold_ready", a_if.imem_req_ready, 0);
            tick();
        end
        a_if.imem_resp_ready = 1'b1;
        nresp = 0;
        cyc   = 0;
        while (nresp < 3 && cyc < 20) begin
            if (a_if.imem_resp_valid) begin
                got_d[nresp] = a_if.imem_resp_data;
                nresp++;
            end
            acc = a_if.imem_req_valid && a_if.imem_req_ready;
            tick();
            cyc++;
            if (acc) a_if.imem_req_valid = 1'b0;
        end
        check("bp_count", nresp, 3);
        check("bp_r0", got_d[0], W0);
        check("bp_r1", got_d[1], W1);
        check("bp_r2", got_d[2], W2);
        a_if.imem_req_valid = 1'b0;
        tick();

        // Error paths.
        fetch_a("misalign", 32'h0000_0402, NOP, 1'b1);
        fetch_a("oor", 32'h0000_0400, NOP, 1'b1);
        fetch_a("after_err", 32'h0, W0, 1'b0);

        // Same-edge load and read: the read sees the old word.
        a_ld_we   = 1'b1;
        a_ld_addr = 8'd2;
        a_ld_data = WNEW;
        fetch_a("same_edge", 32'h8, W2, 1'b0);
        fetch_a("after_ld", 32'h8, WNEW, 1'b0);

        // Reset with two requests in flight.
        a_if.imem_resp_ready = 1'b0;
        a_if.imem_req_valid  = 1'b1;
        a_if.imem_req_addr   = 32'h4;
        tick();
        a_if.imem_req_addr   = 32'h8;
        tick();
        a_if.imem_req_valid  = 1'b0;
        check("mid_pending", a_if.imem_resp_valid, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_valid", a_if.imem_resp_valid, 0);
        check("mid_rst_ready", a_if.imem_req_ready, 1);
        a_if.imem_resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_no_stale", a_if.imem_resp_valid, 0);
        end
        fetch_a("post_rst", 32'h0, W0, 1'b0);

        // Latency sweep on dut_b: continuous requests, ready held high.
        b_if.imem_resp_ready = 1'b1;
        b_if.imem_req_valid  = 1'b1;
        b_if.imem_req_addr   = 32'h0;
        nresp     = 0;
        cyc       = 0;
        issued    = 0;
        first_acc = -1;
        while (nresp < 16 && cyc < 200) begin
            if (b_if.imem_resp_valid) begin
                got_d[nresp] = b_if.imem_resp_data;
                got_e[nresp] = b_if.imem_resp_err;
                got_c[nresp] = cyc;
                nresp++;
            end
            acc = b_if.imem_req_valid && b_if.imem_req_ready;
            if (acc && issued == 0) first_acc = cyc + 1;
            tick();
            cyc++;
            if (acc) begin
                issued++;
                if (issued == 16) b_if.imem_req_valid = 1'b0;
                else b_if.imem_req_addr = 32'(issued * 4);
            end
        end
        check("sweep_count", nresp, 16);
        check("sweep_first_acc", first_acc, 1);
        check("sweep_latency", got_c[0] - first_acc, 3);
        check("sweep_back_to_back", got_c[3] - got_c[0], 3);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("sweep_d%0d", k), got_d[k], b_word(k));
            check($sformatf("sweep_e%0d", k), got_e[k], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
